// File: rtl/ascon_pack.sv
// ascon_pack: round-count constants, FSM state type and start-index decode shared by the permutation sequencer
package ascon_pack;

    localparam logic [3:0] ROUND_START_P12 = 4'd0;
    localparam logic [3:0] ROUND_START_P8  = 4'd4;
    localparam logic [3:0] ROUND_START_P6  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIRST,
        ST_RUN,
        ST_DONE
    } state_t;

    // 00 and 11 both select the full 12-round permutation
    function automatic logic [3:0] start_index(input logic [1:0] sel);
        return (sel == 2'b01) ? ROUND_START_P8 :
               (sel == 2'b10) ? ROUND_START_P6 : ROUND_START_P12;
    endfunction

endpackage

// File: rtl/permutation_sequencer_round_counter.sv
// round_counter: loadable round index that saturates at the last round and flags it
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       increment,
    output logic [3:0] count,
    output logic       last
);

    assign last = (count == ROUND_LAST);

    // clear wins over load, load over increment; the index never moves past the last round
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            count <= 4'd0;
        else if (clear)
            count <= 4'd0;
        else if (load)
            count <= load_value;
        else if (increment && !last)
            count <= count + 4'd1;
    end

endmodule

// File: rtl/permutation_sequencer.sv
// permutation_sequencer: Moore FSM driving round index and state-register control of an Ascon permutation (optional abort_i with PERM_SEQ_ABORT_EN)
module permutation_sequencer
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic [1:0] nrounds_sel_i,
`ifdef PERM_SEQ_ABORT_EN
    input  logic       abort_i,
`endif
    output logic [3:0] round_o,
    output logic       input_select_o,
    output logic       ena_reg_state_o,
    output logic       busy_o,
    output logic       done_o
);

    state_t     state, state_next;
    logic       clear, load, increment, last;
    logic [3:0] count;

    round_counter u_round_counter (
        .clock_i    (clock_i),
        .resetb_i   (resetb_i),
        .clear      (clear),
        .load       (load),
        .load_value (start_index(nrounds_sel_i)),
        .increment  (increment),
        .count      (count),
        .last       (last)
    );

    // state register
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // next state and counter control; the round count is latched only when a start is accepted
    always_comb begin
        state_next = state;
        clear      = 1'b0;
        load       = 1'b0;
        increment  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = ST_FIRST;
                    load       = 1'b1;
                end
            end
            ST_FIRST: begin
                state_next = ST_RUN;
                increment  = 1'b1;
            end
            ST_RUN: begin
                if (last)
                    state_next = ST_DONE;
                else
                    increment = 1'b1;
            end
            ST_DONE: begin
                if (start_i) begin
                    state_next = ST_FIRST;
                    load       = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    clear      = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                clear      = 1'b1;
            end
        endcase
`ifdef PERM_SEQ_ABORT_EN
        if (abort_i && (state == ST_FIRST || state == ST_RUN)) begin
            state_next = ST_IDLE;
            clear      = 1'b1;
            increment  = 1'b0;
        end
`endif
    end

    assign round_o         = count;
    assign input_select_o  = (state == ST_FIRST);
    assign ena_reg_state_o = (state == ST_FIRST) || (state == ST_RUN);
    assign busy_o          = ena_reg_state_o;
    assign done_o          = (state == ST_DONE);

endmodule

// File: tb/tb_permutation_sequencer.sv
// tb_permutation_sequencer: directed self-checking bench for permutation_sequencer
module tb_permutation_sequencer;

    logic       clock_i = 1'b0;
    logic       resetb_i = 1'b0;
    logic       start_i = 1'b0;
    logic [1:0] nrounds_sel_i = 2'b00;
`ifdef PERM_SEQ_ABORT_EN
    logic       abort_i = 1'b0;
`endif
    logic [3:0] round_o;
    logic       input_select_o, ena_reg_state_o, busy_o, done_o;
    logic [7:0] outs;
    int         checks = 0;
    int         errors = 0;

    assign outs = {round_o, input_select_o, ena_reg_state_o, busy_o, done_o};

    permutation_sequencer dut (
        .clock_i         (clock_i),
        .resetb_i        (resetb_i),
        .start_i         (start_i),
        .nrounds_sel_i   (nrounds_sel_i),
`ifdef PERM_SEQ_ABORT_EN
        .abort_i         (abort_i),
`endif
        .round_o         (round_o),
        .input_select_o  (input_select_o),
        .ena_reg_state_o (ena_reg_state_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected output word: {round, input_select, ena, busy, done}
    function automatic logic [7:0] first_w(input int r);
        return {r[3:0], 4'b1110};
    endfunction
    function automatic logic [7:0] run_w(input int r);
        return {r[3:0], 4'b0110};
    endfunction
    localparam logic [7:0] DONE_W = {4'd11, 4'b0001};
    localparam logic [7:0] IDLE_W = 8'h00;

    // one full permutation from IDLE; noisy wiggles start_i and nrounds_sel_i during the run
    task automatic run_seq(input string tag, input logic [1:0] sel, input int s, input bit noisy);
        nrounds_sel_i = sel;
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        check({tag, "_first"}, outs, first_w(s));
        for (int r = s + 1; r <= 11; r++) begin
            if (noisy) begin
                start_i = r[0];
                nrounds_sel_i = r[1:0];
            end
            @(negedge clock_i);
            check({tag, "_run"}, outs, run_w(r));
        end
        start_i = 1'b0;
        nrounds_sel_i = sel;
        @(negedge clock_i);
        check({tag, "_done"}, outs, DONE_W);
        @(negedge clock_i);
        check({tag, "_idle"}, outs, IDLE_W);
    endtask

    initial begin
        repeat (2) @(negedge clock_i);
        check("reset_outs", outs, IDLE_W);
        resetb_i = 1'b1;
        @(negedge clock_i);
        check("idle_no_start", outs, IDLE_W);

        run_seq("p12", 2'b00, 0, 1'b0);
        run_seq("p8", 2'b01, 4, 1'b0);
        run_seq("p6", 2'b10, 6, 1'b0);
        run_seq("p12b", 2'b11, 0, 1'b0);
        run_seq("noisy", 2'b10, 6, 1'b1);

        // back-to-back: p12 then p6 with start_i held through DONE
        nrounds_sel_i = 2'b00;
        start_i = 1'b1;
        @(negedge clock_i);
        check("b2b_first", outs, first_w(0));
        for (int r = 1; r <= 11; r++) begin
            @(negedge clock_i);
            check("b2b_run", outs, run_w(r));
        end
        @(negedge clock_i);
        check("b2b_done", outs, DONE_W);
        nrounds_sel_i = 2'b10;
        @(negedge clock_i);
        check("b2b_first2", outs, first_w(6));
        start_i = 1'b0;
        for (int r = 7; r <= 11; r++) begin
            @(negedge clock_i);
            check("b2b_run2", outs, run_w(r));
        end
        @(negedge clock_i);
        check("b2b_done2", outs, DONE_W);
        @(negedge clock_i);
        check("b2b_idle", outs, IDLE_W);

        // asynchronous reset at round 5
        nrounds_sel_i = 2'b00;
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (5) @(negedge clock_i);
        check("pre_reset_r5", outs, run_w(5));
        #2 resetb_i = 1'b0;
        #1 check("async_reset", outs, IDLE_W);
        @(negedge clock_i);
        check("reset_held", outs, IDLE_W);
        resetb_i = 1'b1;
        @(negedge clock_i);
        check("post_reset_idle", outs, IDLE_W);
        run_seq("after_rst", 2'b00, 0, 1'b0);

`ifdef PERM_SEQ_ABORT_EN
        nrounds_sel_i = 2'b00;
        start_i = 1'b1;
        @(negedge clock_i);
        start_i = 1'b0;
        repeat (3) @(negedge clock_i);
        check("pre_abort_r3", outs, run_w(3));
        abort_i = 1'b1;
        @(negedge clock_i);
        abort_i = 1'b0;
        check("abort_idle", outs, IDLE_W);
        @(negedge clock_i);
        check("abort_no_done", outs, IDLE_W);
        abort_i = 1'b1;
        @(negedge clock_i);
        check("abort_in_idle", outs, IDLE_W);
        abort_i = 1'b0;
        run_seq("after_abort", 2'b01, 4, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/permutation_sequencer.md
PERMUTATION_SEQUENCER -- requirements
Module: permutation_sequencer

Interface
REQ-001 SHALL have no parameters; round counts come from shared package constants.
REQ-002 SHALL use a single clock domain; reset is asynchronous and active-low.
REQ-003 clock_i  input  1  rising-edge clock.
REQ-004 resetb_i  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  request to run one permutation; sampled only in IDLE or DONE.
REQ-006 nrounds_sel_i  input  2  round-count select: 00 = p12, 01 = p8, 10 = p6, 11 = p12; sampled with an accepted start_i.
REQ-007 round_o  output  4  round index (round-constant index 0..11) for the permutation datapath.
REQ-008 input_select_o  output  1  1 selects the external state input; 0 selects state feedback.
REQ-009 ena_reg_state_o  output  1  state register enable for the permutation datapath.
REQ-010 busy_o  output  1  high in FIRST and RUN.
REQ-011 done_o  output  1  one-cycle pulse when the last round has been enabled.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, FIRST, RUN and DONE; all outputs SHALL be decoded from registered state and counter only.
REQ-013 The start index SHALL be 0 for p12, 4 for p8 and 6 for p6; the last index SHALL always be 11.
REQ-014 IDLE: round_o=0, input_select_o=0, ena_reg_state_o=0, busy_o=0, done_o=0.
REQ-015 IDLE with start_i=1 at an edge -> FIRST; round counter loads the start index.
REQ-016 FIRST: input_select_o=1, ena_reg_state_o=1, busy_o=1, round_o=start index; next edge -> RUN with counter+1.
REQ-017 RUN: input_select_o=0, ena_reg_state_o=1, busy_o=1; counter increments each edge; at counter=11 the next edge -> DONE.
REQ-018 DONE: done_o=1, ena_reg_state_o=0, busy_o=0, round_o holds 11; next edge -> FIRST if start_i=1 (back-to-back run), else IDLE.
REQ-019 ena_reg_state_o SHALL be high for exactly 12/8/6 consecutive cycles for p12/p8/p6; done_o SHALL assert on the cycle immediately after the last enabled cycle.
REQ-020 start_i and nrounds_sel_i SHALL be ignored in FIRST and RUN; the running configuration SHALL NOT change mid-permutation.
REQ-021 The counter SHALL never wrap past 11; a value above 11 SHALL NOT be reachable.

Reset
REQ-022 resetb_i low SHALL immediately force IDLE, counter 0 and all outputs 0, in any state, including mid-permutation.
REQ-023 After reset release, the first start_i SHALL be honoured at the first rising edge where it is high.

Configuration
REQ-024 Macro PERM_SEQ_ABORT_EN defined: add input abort_i (1 bit). abort_i=1 in FIRST or RUN -> IDLE at the next edge, with no done_o pulse and counter reset to 0. abort_i is ignored in IDLE and DONE.
REQ-025 Macro PERM_SEQ_ABORT_EN undefined: no abort_i port, and behaviour is exactly REQ-012..REQ-021.

Structure
REQ-026 The constants ROUND_START_P12=0, ROUND_START_P8=4, ROUND_START_P6=6 and ROUND_LAST=11, and the FSM state enum typedef, SHALL live in ascon_pack.
REQ-027 The round counter SHALL be a sub-module, round_counter, with load, increment and a last-round flag; the FSM stays in permutation_sequencer.

Verification
REQ-028 p12: reset released, start_i=1 one cycle, nrounds_sel_i=00 -> round_o 0..11 over 12 cycles, input_select_o=1 only in the round-0 cycle, done_o pulses on cycle 13.
REQ-029 p6: nrounds_sel_i=10 -> round_o 6..11 with ena_reg_state_o high for 6 cycles, then done_o; p8 (01) gives 4..11.
REQ-030 Back-to-back: start_i held high -> DONE goes straight to FIRST; exactly one done_o per run with no IDLE gap.
REQ-031 Mid-run start_i toggling and nrounds_sel_i change during RUN -> sequence unaffected.
REQ-032 resetb_i pulsed low at round 5 -> outputs 0 immediately, no done_o; a new start then runs a full sequence from round 0.
REQ-033 With PERM_SEQ_ABORT_EN defined: abort_i=1 at round 3 -> IDLE next edge, no done_o; without the macro, the abort_i port is absent and elaboration passes.
